// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto a single memory port.
// One outstanding transaction; data has priority with fetch starvation guard.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state;
  state_t      state_nx;
  logic        own_d;
  logic        drop;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  starve_cnt;
  logic        pick_i;
  logic        pick_d;

  // Fetch wins only when data is absent or fetch has waited long enough.
  always_comb begin
    pick_i = i_req_i && !flush_i &&
             (!d_req_i || starve_cnt == LIMIT);
    pick_d = d_req_i && !pick_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (pick_i || pick_d) state_nx = S_REQ;
      S_REQ:  if (mem_gnt_i)        state_nx = S_WAIT;
      S_WAIT: if (mem_rvalid_i)     state_nx = S_IDLE;
      default:                      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    i_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    mem_req_o  = 1'b0;
    i_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    unique case (state)
      S_IDLE: begin
        i_gnt_o = pick_i;
        d_gnt_o = pick_d;
      end
      S_REQ:  mem_req_o = 1'b1;
      S_WAIT: begin
        i_rvalid_o = mem_rvalid_i && !own_d &&
                     !drop && !flush_i;
        d_rvalid_o = mem_rvalid_i && own_d;
      end
      default: ;
    endcase
  end

  assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : 32'h0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Fetch transactions are forced to full-word loads at latch time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_d   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (i_gnt_o) begin
      own_d   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'hF;
      addr_q  <= i_addr_i;
      wdata_q <= 32'h0;
    end else if (d_gnt_o) begin
      own_d   <= 1'b1;
      we_q    <= d_we_i;
      be_q    <= d_be_i;
      addr_q  <= d_addr_i;
      wdata_q <= d_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      starve_cnt <= 3'd0;
    else if (!i_req_i || i_gnt_o)
      starve_cnt <= 3'd0;
    else if (d_gnt_o && starve_cnt != 3'd7)
      starve_cnt <= starve_cnt + 3'd1;
  end

  // A flushed fetch still completes on the bus; only its response is hidden.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      drop <= 1'b0;
    else if (state == S_IDLE)
      drop <= 1'b0;
    else if (flush_i && !own_d)
      drop <= 1'b1;
  end

endmodule
